// File: rtl/ping_pong_pkg.sv
// ----------------------------------------------------------------------------
// ping_pong_pkg
// Shared definitions for the ping-pong buffer controller:
//   - addr_width / cnt_width : word-address and frame-counter widths for a bank
//   - bank_state_e           : coarse state of a bank (write side or read side)
// ----------------------------------------------------------------------------
package ping_pong_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Word address width inside one bank.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counters need one extra bit so that "count == DEPTH" is representable.
  function automatic int cnt_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/ping_pong_buffer.sv
// ----------------------------------------------------------------------------
// ping_pong_buffer
// Two-bank dual-port memory driven by ping_pong_ctrl.
// Ports:
//   clk                 : clock
//   ping_pong           : 1 = port 1 on ping (bank 0), port 2 on pong (bank 1)
//   addr1, din1, we1    : port 1 write
//   addr2, din2, we2    : port 2 (read side; writes possible but normally tied 0)
//   dout2               : port 2 read data, registered (one cycle after addr2)
// Contents are not reset.
// ----------------------------------------------------------------------------
module ping_pong_buffer #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     ping_pong,
  input  logic [$clog2(DEPTH)-1:0] addr1,
  input  logic [BIT_LENGTH-1:0]    din1,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] addr2,
  input  logic [BIT_LENGTH-1:0]    din2,
  input  logic                     we2,
  output logic [BIT_LENGTH-1:0]    dout2
);

  localparam int AW = $clog2(DEPTH);

  logic [BIT_LENGTH-1:0] mem_q [0:(2**(AW+1))-1];

  // Bank bit is the MSB of the index: port 1 uses ~ping_pong, port 2 ping_pong.
  always_ff @(posedge clk) begin
    if (we1) begin
      mem_q[{~ping_pong, addr1}] <= din1;
    end
    if (we2) begin
      mem_q[{ping_pong, addr2}] <= din2;
    end
    dout2 <= mem_q[{ping_pong, addr2}];
  end

endmodule

// File: rtl/ping_pong_ctrl_skid_buffer.sv
// ----------------------------------------------------------------------------
// skid_buffer
// Two-entry valid/ready FIFO used as the output stage of ping_pong_ctrl.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    : upstream (capture) side
//   out_valid_o/out_ready_i/out_data_o : downstream (consumer) side
//   count_o           : current occupancy (0..2)
// ----------------------------------------------------------------------------
module skid_buffer #(
  parameter int BIT_LENGTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BIT_LENGTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BIT_LENGTH-1:0] out_data_o,
  output logic [1:0]            count_o
);

  logic [BIT_LENGTH-1:0] ent0_q, ent0_d;
  logic [BIT_LENGTH-1:0] ent1_q, ent1_d;
  logic [1:0]            count_q, count_d;
  logic                  push_s, pop_s;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = ent0_q;
  assign count_o     = count_q;

  // Entry 0 is always the head; entry 1 holds the second word when full.
  always_comb begin
    push_s  = in_valid_i && in_ready_o;
    pop_s   = out_valid_o && out_ready_i;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d = in_data_i;
        end else begin
          ent1_d = in_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = in_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_data_i;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ping_pong_ctrl.sv
// ----------------------------------------------------------------------------
// ping_pong_ctrl
// Controller for a two-bank ping-pong buffer: a producer stream fills the
// write bank through port 1 while the consumer stream drains the other bank
// through port 2. Banks exchange once the write bank is full and every word of
// the read bank has been fetched into the output skid buffer.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_data   : producer stream
//   rd_valid/rd_ready/rd_data   : consumer stream
//   addr1, din1, we1            : buffer port 1 (write)
//   addr2, dout2                : buffer port 2 (read, dout2 one cycle later)
//   ping_pong                   : bank select, 1 = port 1 on ping
//   swap                        : one-cycle pulse on each bank exchange
// Optional macro PING_PONG_CTRL_LAST_EN adds wr_last (closes a short frame)
// and rd_last (flags the final word of each read frame).
// ----------------------------------------------------------------------------
module ping_pong_ctrl
  import ping_pong_pkg::*;
#(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [BIT_LENGTH-1:0]    wr_data,
`ifdef PING_PONG_CTRL_LAST_EN
  input  logic                     wr_last,
  output logic                     rd_last,
`endif
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [BIT_LENGTH-1:0]    rd_data,
  output logic [$clog2(DEPTH)-1:0] addr1,
  output logic [BIT_LENGTH-1:0]    din1,
  output logic                     we1,
  output logic [$clog2(DEPTH)-1:0] addr2,
  input  logic [BIT_LENGTH-1:0]    dout2,
  output logic                     ping_pong,
  output logic                     swap
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FRAME_LEN = CW'(DEPTH);
`ifdef PING_PONG_CTRL_LAST_EN
  localparam int SW = BIT_LENGTH + 1;  // last flag travels with the word
`else
  localparam int SW = BIT_LENGTH;
`endif

  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] rd_len_q, rd_len_d;
  logic          ping_pong_q, ping_pong_d;
  logic          swap_q, swap_d;
  logic          inflight_q, inflight_d;
`ifdef PING_PONG_CTRL_LAST_EN
  logic          wr_closed_q, wr_closed_d;
  logic          inflight_last_q, inflight_last_d;
`endif

  bank_state_e   wr_state_s, rd_state_s;
  logic          wr_full_s, wr_fire_s, rd_left_s, issue_s, swap_s, pop_s;
  logic [1:0]    skid_count_s, occ_eff_s;
  logic          skid_in_ready_s;
  logic [SW-1:0] skid_in_data_s, skid_out_data_s;

  // Bank states, handshakes and read-issue decision.
  always_comb begin
`ifdef PING_PONG_CTRL_LAST_EN
    wr_full_s = (wr_cnt_q == FRAME_LEN) || wr_closed_q;
`else
    wr_full_s = (wr_cnt_q == FRAME_LEN);
`endif
    if (wr_full_s) begin
      wr_state_s = FULL;
    end else if (wr_cnt_q == '0) begin
      wr_state_s = EMPTY;
    end else begin
      wr_state_s = FILLING;
    end
    rd_left_s  = (rd_cnt_q != rd_len_q);
    rd_state_s = (rd_left_s || inflight_q) ? DRAINING : EMPTY;
    swap_s     = (wr_state_s == FULL) && (rd_state_s == EMPTY);
    wr_fire_s  = wr_valid && !wr_full_s;
    pop_s      = rd_valid && rd_ready;
    // Occupancy after this cycle's pop: counting the pop is what keeps the
    // pipeline at one word per cycle while never over-filling the skid.
    occ_eff_s  = skid_count_s - {1'b0, pop_s};
    issue_s    = rd_left_s && ((occ_eff_s + {1'b0, inflight_q}) < 2'd2)
                 && (skid_in_ready_s || pop_s);
  end

  // Next-state logic for counters, bank select and swap pulse.
  always_comb begin
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    rd_len_d        = rd_len_q;
    ping_pong_d     = ping_pong_q;
    swap_d          = 1'b0;
    inflight_d      = issue_s;
`ifdef PING_PONG_CTRL_LAST_EN
    wr_closed_d     = wr_closed_q;
    inflight_last_d = issue_s && ((rd_cnt_q + CW'(1)) == rd_len_q);
`endif
    if (swap_s) begin
      // Swap never coincides with a write (bank full) or a read issue.
      ping_pong_d = ~ping_pong_q;
      swap_d      = 1'b1;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      rd_len_d    = wr_cnt_q;
`ifdef PING_PONG_CTRL_LAST_EN
      wr_closed_d = 1'b0;
`endif
    end else begin
      if (wr_fire_s) begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
`ifdef PING_PONG_CTRL_LAST_EN
      if (wr_fire_s && wr_last) begin
        wr_closed_d = 1'b1;
      end else begin
        wr_closed_d = wr_closed_q;
      end
`endif
      if (issue_s) begin
        rd_cnt_d = rd_cnt_q + CW'(1);
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      rd_len_q        <= '0;
      ping_pong_q     <= 1'b1;
      swap_q          <= 1'b0;
      inflight_q      <= 1'b0;
`ifdef PING_PONG_CTRL_LAST_EN
      wr_closed_q     <= 1'b0;
      inflight_last_q <= 1'b0;
`endif
    end else begin
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_len_q        <= rd_len_d;
      ping_pong_q     <= ping_pong_d;
      swap_q          <= swap_d;
      inflight_q      <= inflight_d;
`ifdef PING_PONG_CTRL_LAST_EN
      wr_closed_q     <= wr_closed_d;
      inflight_last_q <= inflight_last_d;
`endif
    end
  end

`ifdef PING_PONG_CTRL_LAST_EN
  assign skid_in_data_s = {inflight_last_q, dout2};
  assign rd_last        = skid_out_data_s[BIT_LENGTH];
`else
  assign skid_in_data_s = dout2;
`endif
  assign rd_data   = skid_out_data_s[BIT_LENGTH-1:0];
  assign wr_ready  = !wr_full_s;
  assign we1       = wr_fire_s;
  assign addr1     = wr_cnt_q[AW-1:0];
  assign din1      = wr_data;
  assign addr2     = rd_cnt_q[AW-1:0];
  assign ping_pong = ping_pong_q;
  assign swap      = swap_q;

  skid_buffer #(.BIT_LENGTH(SW)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (inflight_q),
    .in_ready_o (skid_in_ready_s),
    .in_data_i  (skid_in_data_s),
    .out_valid_o(rd_valid),
    .out_ready_i(rd_ready),
    .out_data_o (skid_out_data_s),
    .count_o    (skid_count_s)
  );

endmodule

// File: tb/tb_ping_pong_ctrl.sv
module tb_ping_pong_ctrl;

  localparam int BL = 32;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [BL-1:0] wr_data, rd_data, din1, dout2;
  logic [AW-1:0] addr1, addr2;
  logic          we1, ping_pong, swap;
  logic          we2_s;
  logic [BL-1:0] din2_s;
`ifdef PING_PONG_CTRL_LAST_EN
  logic          wr_last, rd_last;
  bit            last_q[$];
`endif

  assign we2_s  = 1'b0;
  assign din2_s = '0;

  always #5 clk = ~clk;

  ping_pong_ctrl #(.BIT_LENGTH(BL), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
`ifdef PING_PONG_CTRL_LAST_EN
    .wr_last(wr_last), .rd_last(rd_last),
`endif
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .addr1(addr1), .din1(din1), .we1(we1),
    .addr2(addr2), .dout2(dout2),
    .ping_pong(ping_pong), .swap(swap)
  );

  ping_pong_buffer #(.BIT_LENGTH(BL), .DEPTH(DP)) u_mem (
    .clk(clk), .ping_pong(ping_pong),
    .addr1(addr1), .din1(din1), .we1(we1),
    .addr2(addr2), .din2(din2_s), .we2(we2_s),
    .dout2(dout2)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_acc    = 0;
  int            n_rd     = 0;
  logic [BL-1:0] exp_q[$];
  logic [BL-1:0] wdat;
  logic          acc_f, pop_f;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: record accepted writes and check delivered words, then
  // advance to the next falling edge.
  task automatic cyc();
    logic [BL-1:0] e;
    #1;
    acc_f = wr_valid && wr_ready;
    pop_f = rd_valid && rd_ready;
    if (pop_f) begin
      chk("rd_have_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data_order", 64'(rd_data), 64'(e));
`ifdef PING_PONG_CTRL_LAST_EN
        chk("rd_last", 64'(rd_last), 64'(last_q.pop_front()));
`endif
        n_rd++;
      end
    end
    if (acc_f) begin
      // Two banks plus at most two leftover words in the output stage.
      chk("capacity", 64'(exp_q.size() <= 2 * DP + 1), 64'd1);
      exp_q.push_back(wr_data);
`ifdef PING_PONG_CTRL_LAST_EN
      last_q.push_back(wr_last);
`endif
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
`ifdef PING_PONG_CTRL_LAST_EN
    wr_last  = 1'b0;
`endif
    #1;
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    chk({tag, "_ping_pong"}, 64'(ping_pong), 64'd1);
    chk({tag, "_swap"}, 64'(swap), 64'd0);
    chk({tag, "_we1"}, 64'(we1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
`ifdef PING_PONG_CTRL_LAST_EN
    last_q.delete();
`endif
    n_acc = 0;
    wdat  = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < budget && exp_q.size() > 0; k++) cyc();
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    wdat     = '0;
`ifdef PING_PONG_CTRL_LAST_EN
    wr_last  = 1'b0;
`endif
    @(negedge clk);
    do_reset("init");

    // One frame written back-to-back, then read at full rate.
    rd_ready = 1'b1;
    for (int i = 0; i < DP; i++) begin
      wr_valid = 1'b1;
      wr_data  = BL'(i);
      #1;
      chk("we1", 64'(we1), 64'd1);
      chk("addr1", 64'(addr1), 64'(i));
      chk("din1", 64'(din1), 64'(i));
      cyc();
    end
    wr_valid = 1'b0;
    #1;
    chk("swap_before", 64'(swap), 64'd0);
    chk("wr_ready_full", 64'(wr_ready), 64'd0);
    cyc();
    #1;
    chk("swap_pulse", 64'(swap), 64'd1);
    chk("ping_pong_toggled", 64'(ping_pong), 64'd0);
    cyc();
    #1;
    chk("swap_one_cycle", 64'(swap), 64'd0);
    chk("rd_valid_latency", 64'(rd_valid), 64'd0);
    cyc();
    for (int k = 0; k < DP; k++) begin
      #1;
      chk("rd_valid_stream", 64'(rd_valid), 64'd1);
      cyc();
    end
    #1;
    chk("rd_valid_after_frame", 64'(rd_valid), 64'd0);
    chk("frame_drained", 64'(exp_q.size()), 64'd0);

    // 64 words with both sides at full rate.
    wdat = '0;
    base = n_rd;
    rd_ready = 1'b1;
    for (int k = 0; k < 400 && (n_rd - base) < 64; k++) begin
      wr_valid = (wdat < BL'(64));
      wr_data  = wdat;
      cyc();
      if (acc_f) wdat++;
    end
    chk("stream64_count", 64'(n_rd - base), 64'd64);

    // Random valid/ready traffic, topped up to whole frames and drained.
    for (int k = 0; k < 300; k++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = BL'($urandom);
      rd_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    for (int k = 0; k < 200 && (n_acc % DP) != 0; k++) begin
      wr_valid = 1'b1;
      wr_data  = BL'($urandom);
      rd_ready = $urandom_range(0, 1) != 0;
      cyc();
    end
    chk("random_topup", 64'(n_acc % DP), 64'd0);
    drain("random_drain", 300);

    // Consumer stalled: writer blocks after two banks.
    do_reset("stall_reset");
    rd_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wr_valid = 1'b1;
      wr_data  = wdat;
      cyc();
      if (acc_f) wdat++;
    end
    chk("stall_accepted", 64'(n_acc), 64'(2 * DP));
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      #1;
      chk("stall_wr_ready", 64'(wr_ready), 64'd0);
      chk("stall_rd_valid", 64'(rd_valid), 64'd1);
      chk("stall_rd_data", 64'(rd_data), 64'd0);
      cyc();
    end
    drain("stall_drain", 200);

    // Consumer toggling ready while two frames pass through.
    base = n_acc;
    for (int k = 0; k < 300 && (n_acc - base) < 2 * DP; k++) begin
      wr_valid = 1'b1;
      wr_data  = wdat;
      rd_ready = k[0];
      cyc();
      if (acc_f) wdat++;
    end
    chk("toggle_written", 64'(n_acc - base), 64'(2 * DP));
    wr_valid = 1'b0;
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
      rd_ready = ~rd_ready;
      cyc();
    end
    chk("toggle_drain", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of traffic: 16 + 7 written, 3 read.
    base = n_acc;
    rd_ready = 1'b0;
    for (int k = 0; k < 200 && (n_acc - base) < DP + 7; k++) begin
      wr_valid = 1'b1;
      wr_data  = wdat;
      cyc();
      if (acc_f) wdat++;
    end
    wr_valid = 1'b0;
    base = n_rd;
    for (int k = 0; k < 50 && (n_rd - base) < 3; k++) begin
      rd_ready = 1'b1;
      cyc();
    end
    chk("pre_reset_reads", 64'(n_rd - base), 64'd3);
    do_reset("mid_reset");
    base = n_rd;
    rd_ready = 1'b1;
    for (int i = 0; i < DP; i++) begin
      wr_valid = 1'b1;
      wr_data  = BL'(100 + i);
      cyc();
    end
    drain("fresh_drain", 100);
    chk("fresh_count", 64'(n_rd - base), 64'(DP));

`ifdef PING_PONG_CTRL_LAST_EN
    // Short frame closed by wr_last on its fifth word.
    do_reset("last_reset");
    base = n_rd;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = BL'(i);
      wr_last  = (i == 4);
      cyc();
    end
    wr_last = 1'b0;
    drain("last_drain", 100);
    chk("last_count", 64'(n_rd - base), 64'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
